// File: rtl/trojan_pkg.sv
// trojan_pkg
// Shared types and widths for the trojan trigger controller.
//   trig_state_t : controller state (IDLE, COUNT, FIRE)
//   TRIG_CNT_W   : width of the consecutive-match counter
//   TRIG_PAY_W   : width of the payload-window counter
//   TRIG_TMO_W   : width of the optional idle-gap counter
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } trig_state_t;

    localparam int TRIG_CNT_W = 4;
    localparam int TRIG_PAY_W = 16;
    localparam int TRIG_TMO_W = 16;

endpackage

// File: rtl/trig_down_counter.sv
// trig_down_counter
// Loadable saturating counter. With UP=0 it counts down and sticks at zero
// (payload window). With UP=1 it counts up and sticks at all-ones (idle-gap
// counter); loading zero acts as a clear in that mode.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, count -> 0
//   load     : load load_val this cycle (has priority over step)
//   load_val : value to load
//   step     : advance one count in the configured direction
//   count    : current value (registered)
module trig_down_counter #(
    parameter int W  = 16,
    parameter bit UP = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (step) begin
            if (UP) begin
                if (count_reg != '1) begin
                    count_reg <= count_reg + W'(1);
                end
            end else begin
                if (count_reg != '0) begin
                    count_reg <= count_reg - W'(1);
                end
            end
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/trojan_trigger_ctrl.sv
// trojan_trigger_ctrl
// Qualifies comparator results with the plaintext strobe, fires the payload
// after MATCH_COUNT consecutive qualified matches and then holds payload_en
// for PAYLOAD_CYCLES cycles. The FIRE window cannot be interrupted except by
// rst.
// Optional build macro TRIG_TIMEOUT_EN: abandons a partial match run after
// TIMEOUT_CYCLES cycles in COUNT without a qualified event.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   enable     : trigger enable; low drops a partial run back to IDLE
//   pt_valid   : one-cycle strobe, new plaintext at the comparator
//   cmp_match  : comparator result, used only with pt_valid
//   payload_en : payload enable (registered)
//   fire_pulse : one-cycle pulse on the first payload_en cycle (registered)
//   armed      : high while a partial match run is in progress (registered)
//   match_cnt  : current consecutive-match count (registered)
module trojan_trigger_ctrl
    import trojan_pkg::*;
#(
    parameter int MATCH_COUNT    = 3,
    parameter int PAYLOAD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pt_valid,
    input  logic                  cmp_match,
    output logic                  payload_en,
    output logic                  fire_pulse,
    output logic                  armed,
    output logic [TRIG_CNT_W-1:0] match_cnt
);

    localparam logic [TRIG_CNT_W-1:0] MC_VAL   = TRIG_CNT_W'(MATCH_COUNT);
    localparam logic [TRIG_PAY_W-1:0] PAY_INIT = TRIG_PAY_W'(PAYLOAD_CYCLES - 1);

    trig_state_t           state_reg, state_next;
    logic [TRIG_CNT_W-1:0] match_cnt_reg, match_cnt_next;
    logic                  payload_en_reg, fire_pulse_reg, armed_reg;

    logic                  qual_event;
    logic                  pay_load, pay_step;
    logic [TRIG_PAY_W-1:0] pay_cnt;
    logic                  gap_expired;

    assign qual_event = pt_valid & enable;

    // Payload window: loaded with PAYLOAD_CYCLES-1 on FIRE entry, the FSM
    // leaves FIRE on the cycle it reads zero, giving exactly PAYLOAD_CYCLES
    // cycles of payload_en.
    trig_down_counter #(
        .W  (TRIG_PAY_W),
        .UP (1'b0)
    ) u_pay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pay_load),
        .load_val (PAY_INIT),
        .step     (pay_step),
        .count    (pay_cnt)
    );

`ifdef TRIG_TIMEOUT_EN
    logic [TRIG_TMO_W-1:0] gap_cnt;
    logic                  gap_clear;

    // Held at zero outside COUNT and cleared by every qualified event, so it
    // measures cycles since the last event of the current run.
    assign gap_clear = (state_reg != COUNT) | qual_event;

    trig_down_counter #(
        .W  (TRIG_TMO_W),
        .UP (1'b1)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_clear),
        .load_val ('0),
        .step     (1'b1),
        .count    (gap_cnt)
    );

    // The current idle cycle is gap number gap_cnt+1; expire when that
    // reaches TIMEOUT_CYCLES. The FSM checks events first, so an event in
    // the same cycle still wins.
    assign gap_expired = (gap_cnt >= TRIG_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_tmo_cfg;
    assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
    assign gap_expired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            match_cnt_reg  <= '0;
            payload_en_reg <= 1'b0;
            fire_pulse_reg <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            match_cnt_reg  <= match_cnt_next;
            payload_en_reg <= (state_next == FIRE);
            fire_pulse_reg <= (state_next == FIRE) && (state_reg != FIRE);
            armed_reg      <= (state_next == COUNT);
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        pay_step       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (qual_event && cmp_match) begin
                    match_cnt_next = TRIG_CNT_W'(1);
                    state_next     = (MATCH_COUNT == 1) ? FIRE : COUNT;
                end
            end

            COUNT: begin
                // enable low outranks any strobe in the same cycle
                if (!enable) begin
                    match_cnt_next = '0;
                    state_next     = IDLE;
                end else if (pt_valid) begin
                    if (cmp_match) begin
                        match_cnt_next = match_cnt_reg + TRIG_CNT_W'(1);
                        if (match_cnt_next == MC_VAL) begin
                            state_next = FIRE;
                        end
                    end else begin
                        match_cnt_next = '0;
                        state_next     = IDLE;
                    end
                end else if (gap_expired) begin
                    match_cnt_next = '0;
                    state_next     = IDLE;
                end
            end

            FIRE: begin
                // All inputs ignored; a strobe in the last cycle is dropped.
                if (pay_cnt == '0) begin
                    match_cnt_next = '0;
                    state_next     = IDLE;
                end else begin
                    pay_step = 1'b1;
                end
            end

            default: begin
                match_cnt_next = '0;
                state_next     = IDLE;
            end
        endcase
    end

    assign pay_load   = (state_next == FIRE) && (state_reg != FIRE);

    assign payload_en = payload_en_reg;
    assign fire_pulse = fire_pulse_reg;
    assign armed      = armed_reg;
    assign match_cnt  = match_cnt_reg;

endmodule

// File: tb/tb_trojan_trigger_ctrl.sv
// tb_trojan_trigger_ctrl
// Directed scenarios followed by randomized traffic, each cycle compared with
// a behavioural model that tracks the match run length, the number of
// payload cycles left and (with TRIG_TIMEOUT_EN) the idle gap as integers.
module tb_trojan_trigger_ctrl;

    localparam int MC  = 3;
    localparam int PAY = 16;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pt_valid = 1'b0;
    logic       cmp_match = 1'b0;
    logic       payload_en, fire_pulse, armed;
    logic [3:0] match_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_run  = 0;   // consecutive qualified matches so far
    int m_pay  = 0;   // payload cycles still to come (incl. the current one)
    int m_gap  = 0;   // idle cycles since last qualified event in a run
    int m_fire = 0;   // fire happened on the last edge

    // observed-output tallies for window-length checks
    int pay_seen  = 0;
    int fire_seen = 0;

    trojan_trigger_ctrl #(
        .MATCH_COUNT    (MC),
        .PAYLOAD_CYCLES (PAY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pt_valid   (pt_valid),
        .cmp_match  (cmp_match),
        .payload_en (payload_en),
        .fire_pulse (fire_pulse),
        .armed      (armed),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic v, input logic m);
        m_fire = 0;
        if (r) begin
            m_run = 0;
            m_pay = 0;
            m_gap = 0;
        end else if (m_pay > 0) begin
            m_pay--;
            if (m_pay == 0) m_run = 0;
        end else if (!e) begin
            m_run = 0;
            m_gap = 0;
        end else if (v) begin
            m_gap = 0;
            if (m) begin
                m_run++;
                if (m_run == MC) begin
                    m_pay  = PAY;
                    m_fire = 1;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_run > 0) begin
`ifdef TRIG_TIMEOUT_EN
            m_gap++;
            if (m_gap >= TMO) begin
                m_run = 0;
                m_gap = 0;
            end
`endif
        end
    endtask

    // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic v, input logic m);
        rst = r; enable = e; pt_valid = v; cmp_match = m;
        @(posedge clk);
        model_update(r, e, v, m);
        #1;
        chk("payload_en", 32'(payload_en), 32'(m_pay > 0));
        chk("fire_pulse", 32'(fire_pulse), 32'(m_fire));
        chk("armed",      32'(armed),      32'(m_run > 0 && m_pay == 0));
        chk("match_cnt",  32'(match_cnt),  32'(m_run));
        if (payload_en === 1'b1) pay_seen++;
        if (fire_pulse === 1'b1) fire_seen++;
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_payload_en", 32'(payload_en), 32'd0);
        chk("reset_match_cnt",  32'(match_cnt),  32'd0);

        // three consecutive matches -> 16-cycle window, single fire pulse
        pay_seen = 0; fire_seen = 0;
        step(0, 1, 1, 1); chk("seq_cnt1", 32'(match_cnt), 32'd1);
        step(0, 1, 1, 1); chk("seq_cnt2", 32'(match_cnt), 32'd2);
        step(0, 1, 1, 1); chk("seq_cnt3", 32'(match_cnt), 32'd3);
        chk("fire_latency", 32'(payload_en), 32'd1);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
        chk("window_len",  32'(pay_seen),  32'd16);
        chk("fire_pulses", 32'(fire_seen), 32'd1);
        chk("after_window_cnt", 32'(match_cnt), 32'd0);

        // match, match, non-match, match x3
        pay_seen = 0;
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        step(0, 1, 1, 0); chk("nonmatch_clear", 32'(match_cnt), 32'd0);
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        chk("no_early_fire", 32'(pay_seen), 32'd0);
        step(0, 1, 1, 1); chk("fire_after_three", 32'(payload_en), 32'd1);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);

        // two matches, enable low one cycle, then three matches
        pay_seen = 0;
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        step(0, 0, 1, 1); chk("enable_low_clear", 32'(match_cnt), 32'd0);
        step(0, 1, 1, 1); chk("enable_no_fire", 32'(pay_seen), 32'd0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1); chk("enable_refire", 32'(payload_en), 32'd1);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);

        // strobes during FIRE are ignored, including in the last cycle
        pay_seen = 0;
        step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 1'($urandom_range(0, 1)));
        chk("fire_ignore_window", 32'(pay_seen), 32'd16);
        chk("fire_ignore_cnt",    32'(match_cnt), 32'd0);
        step(0, 1, 1, 1); chk("restart_cnt", 32'(match_cnt), 32'd1);
        step(0, 1, 1, 0);

        // rst on the 5th FIRE cycle
        step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_fire_payload", 32'(payload_en), 32'd0);
        chk("rst_fire_cnt",     32'(match_cnt),  32'd0);
        step(0, 1, 1, 1); chk("rst_then_match", 32'(match_cnt), 32'd1);
        step(0, 1, 1, 0);

`ifdef TRIG_TIMEOUT_EN
        // one match then 8 idle cycles -> timeout
        step(0, 1, 1, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        chk("tmo_still_armed", 32'(armed), 32'd1);
        step(0, 1, 0, 0);
        chk("tmo_expired_cnt",   32'(match_cnt), 32'd0);
        chk("tmo_expired_armed", 32'(armed),     32'd0);
        // event on the 8th gap cycle keeps the run alive
        step(0, 1, 1, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        chk("tmo_event_wins", 32'(match_cnt), 32'd2);
        step(0, 1, 1, 0);
`else
        // without the timeout a partial run persists
        step(0, 1, 1, 1);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
        chk("no_tmo_armed", 32'(armed),     32'd1);
        chk("no_tmo_cnt",   32'(match_cnt), 32'd1);
        step(0, 1, 1, 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 15) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
